// File: rtl/dm_responder.sv
// Data-memory responder: serves one load/store at a time over req/ack on a word-wide
// synchronous RAM, with read-modify-write sub-word stores and an independent debug read port.
module dm_responder #(
    parameter int unsigned ADDR_NBIT = 12,
    parameter int unsigned OP_NBIT   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 req,
    input  logic                 we,
    input  logic [OP_NBIT-1:0]   op,
    input  logic [ADDR_NBIT-1:0] addr,
    input  logic [31:0]          data_in,
    output logic                 ack,
    output logic                 err,
    output logic [31:0]          data,
    output logic                 busy,
    input  logic [ADDR_NBIT-3:0] dbg_addr,
    output logic [31:0]          dbg_data
);

    localparam int unsigned WORD_NBIT = ADDR_NBIT - 2;
    localparam int unsigned DEPTH     = 2 ** WORD_NBIT;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RMW  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   we_q, we_d;
    logic [OP_NBIT-1:0]     op_q, op_d;
    logic [ADDR_NBIT-1:0]   addr_q, addr_d;
    logic [15:0]            wdata_q, wdata_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic [31:0]            data_q, data_d;
    logic                   busy_q, busy_d;
    logic [31:0]            dbg_q;

    logic [31:0]            mem [DEPTH];
    logic [31:0]            rd_q;
    logic                   rd_en;
    logic                   mem_we;
    logic [WORD_NBIT-1:0]   mem_widx;
    logic [31:0]            mem_wdata;

    logic                   req_word, req_half, req_aligned;
    logic [7:0]             lane_b;
    logic [15:0]            lane_h;
    logic [31:0]            load_val;
    logic [31:0]            merged;

    // Request decode: size 11 behaves as a word access
    always_comb begin
        req_word    = (op[1:0] == 2'b00) || (op[1:0] == 2'b11);
        req_half    = (op[1:0] == 2'b01);
        req_aligned = req_word ? (addr[1:0] == 2'b00) :
                      req_half ? (addr[0] == 1'b0) : 1'b1;
    end

    // Lane extraction for loads and lane merge for sub-word stores, from the RAM word read at accept
    always_comb begin
        lane_b = rd_q[7:0];
        case (addr_q[1:0])
            2'd1:    lane_b = rd_q[15:8];
            2'd2:    lane_b = rd_q[23:16];
            2'd3:    lane_b = rd_q[31:24];
            default: lane_b = rd_q[7:0];
        endcase
        lane_h = addr_q[1] ? rd_q[31:16] : rd_q[15:0];

        case (op_q[1:0])
            2'b01:   load_val = op_q[2] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            2'b10:   load_val = op_q[2] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            default: load_val = rd_q;
        endcase

        merged = rd_q;
        if (op_q[1:0] == 2'b01) begin
            if (addr_q[1]) merged[31:16] = wdata_q;
            else           merged[15:0]  = wdata_q;
        end else begin
            case (addr_q[1:0])
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                2'd3:    merged[31:24] = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = 1'b0;
        data_d    = data_q;
        rd_en     = 1'b0;
        mem_we    = 1'b0;
        mem_widx  = addr[ADDR_NBIT-1:2];
        mem_wdata = data_in;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (!req_aligned) begin
                        err_d   = 1'b1;
                        data_d  = 32'd0;
                        state_d = S_ACK;
                    end else if (we && req_word) begin
                        mem_we  = 1'b1;
                        data_d  = 32'd0;
                        state_d = S_ACK;
                    end else begin
                        rd_en   = 1'b1;
                        we_d    = we;
                        op_d    = op;
                        addr_d  = addr;
                        wdata_d = data_in[15:0];
                        state_d = S_RMW;
                    end
                end
            end
            S_RMW: begin
                if (we_q) begin
                    mem_we    = 1'b1;
                    mem_widx  = addr_q[ADDR_NBIT-1:2];
                    mem_wdata = merged;
                    data_d    = 32'd0;
                end else begin
                    data_d    = load_val;
                end
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ack_d  = (state_d == S_ACK);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            we_q    <= we_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    // RAM: no write during reset or freeze, so an abandoned RMW never lands
    always_ff @(posedge clk) begin
        if (mem_we && en && rst_n) begin
            mem[mem_widx] <= mem_wdata;
        end
        if (rd_en && en) begin
            rd_q <= mem[addr[ADDR_NBIT-1:2]];
        end
    end

    // Debug port reads every edge; same-edge writes return the old word
    always_ff @(posedge clk) begin
        if (!rst_n) dbg_q <= 32'd0;
        else        dbg_q <= mem[dbg_addr];
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign data     = data_q;
    assign busy     = busy_q;
    assign dbg_data = dbg_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed vector table, multi-cycle corner sequences, and random
// traffic checked against a byte-addressed little-endian memory model.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        rst_n, en, req, we;
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] data_in;
    logic        ack, err, busy;
    logic [31:0] data, dbg_data;
    logic [9:0]  dbg_addr;

    int tests = 0;
    int fails = 0;

    logic [7:0] mb [256];

    dm_responder dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .we(we), .op(op),
        .addr(addr), .data_in(data_in), .ack(ack), .err(err), .data(data),
        .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        w;
        logic [2:0]  o;
        logic [11:0] a;
        logic [31:0] d;
        logic        e_err;
        logic [31:0] e_data;
        int          e_lat;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] o);
        return (o[1:0] == 2'b01) ? 2 : (o[1:0] == 2'b10) ? 1 : 4;
    endfunction

    // Model: assemble n little-endian bytes, then extend from the top byte
    function automatic logic [31:0] m_load(input int a, input int n, input bit uns);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(mb[(a + k) % 256]) << (8 * k));
        if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic m_store(input int a, input int n, input logic [31:0] d);
        for (int k = 0; k < n; k++) mb[(a + k) % 256] = 8'(d >> (8 * k));
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 10) begin
            @(posedge clk); #1;
            g++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_ack(output int lat);
        lat = 1;
        while (!ack && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic xact(input string nm, input logic w, input logic [2:0] o, input logic [11:0] a,
                        input logic [31:0] d, input logic e_err, input logic [31:0] e_data,
                        input int e_lat);
        int lat;
        wait_idle();
        we = w; op = o; addr = a; data_in = d; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        wait_ack(lat);
        chk({nm, " ack"}, 32'(ack), 32'd1);
        chk({nm, " latency"}, 32'(lat), 32'(e_lat));
        chk({nm, " err"}, 32'(err), 32'(e_err));
        chk({nm, " data"}, data, e_data);
    endtask

    initial begin
        int lat;
        logic        w;
        logic [2:0]  o;
        logic [11:0] a;
        logic [31:0] d, e_data;
        logic        mis;
        int          n;

        tbl[0]  = '{1'b1, 3'd0, 12'h010, 32'hDEADBEEF, 1'b0, 32'h0,        1};
        tbl[1]  = '{1'b0, 3'd0, 12'h010, 32'h0,        1'b0, 32'hDEADBEEF, 2};
        tbl[2]  = '{1'b1, 3'd0, 12'h010, 32'h11223344, 1'b0, 32'h0,        1};
        tbl[3]  = '{1'b1, 3'd2, 12'h012, 32'hAAAAAA80, 1'b0, 32'h0,        2};
        tbl[4]  = '{1'b0, 3'd2, 12'h012, 32'h0,        1'b0, 32'hFFFFFF80, 2};
        tbl[5]  = '{1'b0, 3'd6, 12'h012, 32'h0,        1'b0, 32'h00000080, 2};
        tbl[6]  = '{1'b0, 3'd0, 12'h010, 32'h0,        1'b0, 32'h11803344, 2};
        tbl[7]  = '{1'b1, 3'd0, 12'h020, 32'h0,        1'b0, 32'h0,        1};
        tbl[8]  = '{1'b1, 3'd1, 12'h022, 32'h1234BEEF, 1'b0, 32'h0,        2};
        tbl[9]  = '{1'b0, 3'd1, 12'h022, 32'h0,        1'b0, 32'hFFFFBEEF, 2};
        tbl[10] = '{1'b0, 3'd5, 12'h022, 32'h0,        1'b0, 32'h0000BEEF, 2};
        tbl[11] = '{1'b0, 3'd0, 12'h011, 32'h0,        1'b1, 32'h0,        1};
        tbl[12] = '{1'b1, 3'd1, 12'h023, 32'h5555AAAA, 1'b1, 32'h0,        1};
        tbl[13] = '{1'b0, 3'd0, 12'h020, 32'h0,        1'b0, 32'hBEEF0000, 2};
        tbl[14] = '{1'b0, 3'd3, 12'h010, 32'h0,        1'b0, 32'h11803344, 2};
        tbl[15] = '{1'b1, 3'd0, 12'h012, 32'h99999999, 1'b1, 32'h0,        1};
        tbl[16] = '{1'b0, 3'd2, 12'h013, 32'h0,        1'b0, 32'h00000011, 2};

        for (int i = 0; i < 256; i++) mb[i] = 8'h00;

        // Reset held for two edges with a word store pending
        rst_n = 1'b0; en = 1'b1; req = 1'b1; we = 1'b1; op = 3'd0;
        addr = 12'h050; data_in = 32'h12345678; dbg_addr = 10'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ack", 32'(ack), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset data", data, 32'd0);
        chk("reset dbg_data", dbg_data, 32'd0);
        req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            xact($sformatf("tbl%0d", i), tbl[i].w, tbl[i].o, tbl[i].a, tbl[i].d,
                 tbl[i].e_err, tbl[i].e_data, tbl[i].e_lat);
            if (tbl[i].w && !tbl[i].e_err)
                m_store(int'(tbl[i].a), nbytes(tbl[i].o), tbl[i].d);
        end

        // Byte store frozen by en=0 for three cycles while in RMW
        xact("stall_pre", 1'b1, 3'd0, 12'h030, 32'h55667788, 1'b0, 32'h0, 1);
        m_store(12'h030, 4, 32'h55667788);
        wait_idle();
        we = 1'b1; op = 3'd2; addr = 12'h031; data_in = 32'hFFFFFF99; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        chk("stall busy", 32'(busy), 32'd1);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall ack%0d", k), 32'(ack), 32'd0);
        end
        en = 1'b1;
        wait_ack(lat);
        chk("stall ack", 32'(ack), 32'd1);
        chk("stall latency", 32'(3 + lat), 32'd5);
        chk("stall err", 32'(err), 32'd0);
        m_store(12'h031, 1, 32'h99);
        xact("stall_load", 1'b0, 3'd0, 12'h030, 32'h0, 1'b0, 32'h55669988, 2);

        // Reset asserted during RMW of a byte store: word must be untouched
        xact("rmwrst_pre", 1'b1, 3'd0, 12'h040, 32'hCAFEF00D, 1'b0, 32'h0, 1);
        m_store(12'h040, 4, 32'hCAFEF00D);
        wait_idle();
        we = 1'b1; op = 3'd2; addr = 12'h040; data_in = 32'h00000011; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rmwrst ack", 32'(ack), 32'd0);
        chk("rmwrst busy", 32'(busy), 32'd0);
        dbg_addr = 10'd16;
        @(posedge clk); #1;
        chk("rmwrst dbg", dbg_data, 32'hCAFEF00D);
        xact("rmwrst_load", 1'b0, 3'd6, 12'h040, 32'h0, 1'b0, 32'h0000000D, 2);

        // Reset in IDLE with a word store requested: no write
        xact("idlerst_pre", 1'b1, 3'd0, 12'h050, 32'h0BADF00D, 1'b0, 32'h0, 1);
        m_store(12'h050, 4, 32'h0BADF00D);
        wait_idle();
        rst_n = 1'b0; req = 1'b1; we = 1'b1; op = 3'd0; addr = 12'h050; data_in = 32'h12345678;
        repeat (2) @(posedge clk);
        #1;
        chk("idlerst ack", 32'(ack), 32'd0);
        chk("idlerst busy", 32'(busy), 32'd0);
        req = 1'b0;
        rst_n = 1'b1;
        dbg_addr = 10'd20;
        @(posedge clk); #1;
        chk("idlerst dbg", dbg_data, 32'h0BADF00D);

        // Random traffic over words 0..15 against the byte model
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            xact($sformatf("fill%0d", i), 1'b1, 3'd0, 12'(4 * i), d, 1'b0, 32'h0, 1);
            m_store(4 * i, 4, d);
        end
        for (int i = 0; i < 200; i++) begin
            w = 1'($urandom_range(0, 1));
            o = 3'($urandom_range(0, 7));
            a = 12'($urandom_range(0, 63));
            d = $urandom;
            n = nbytes(o);
            mis = (int'(a) % n) != 0;
            if (mis) begin
                xact($sformatf("rnd%0d", i), w, o, a, d, 1'b1, 32'h0, 1);
            end else if (w) begin
                xact($sformatf("rnd%0d", i), w, o, a, d, 1'b0, 32'h0, (n == 4) ? 1 : 2);
                m_store(int'(a), n, d);
            end else begin
                e_data = m_load(int'(a), n, o[2]);
                xact($sformatf("rnd%0d", i), w, o, a, d, 1'b0, e_data, 2);
            end
        end

        for (int i = 0; i < 16; i++) begin
            dbg_addr = 10'(i);
            @(posedge clk); #1;
            chk($sformatf("dbg%0d", i), dbg_data, m_load(4 * i, 4, 1'b1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
